// File: rtl/rgb_csc_writer.sv
// YUV->RGB colour-space converter with packed 16-bit SRAM word writer.
// Optional saturating clip counter enabled by defining CSC_CLIP_COUNT_EN.
module rgb_csc_writer #(
    parameter int BASE_ADDR  = 146944,
    parameter int NUM_PIXELS = 76800
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_y,
    input  logic [7:0]  in_u,
    input  logic [7:0]  in_v,
    output logic        in_ready,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        done,
    output logic [16:0] clip_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam int CW = $clog2(NUM_PIXELS + 1);
    localparam logic [CW-1:0] NP    = CW'(NUM_PIXELS);
    localparam logic [CW-1:0] NP_M1 = CW'(NUM_PIXELS - 1);
    localparam logic [17:0] BASE = 18'(BASE_ADDR);
    localparam logic [17:0] LAST = 18'(BASE_ADDR + 3 * NUM_PIXELS / 2 - 1);

    localparam logic signed [31:0] K_Y  = 32'sd76284;
    localparam logic signed [31:0] K_RV = 32'sd104595;
    localparam logic signed [31:0] K_GU = 32'sd25624;
    localparam logic signed [31:0] K_GV = 32'sd53281;
    localparam logic signed [31:0] K_BU = 32'sd132251;

    logic [1:0]    state;
    logic [CW-1:0] pix_cnt;
    logic          w2_pend;
    logic          last_q;
    logic          advance;
    logic          accept;
    logic          go;

    logic              a_valid, a_odd;
    logic signed [8:0] a_y, a_u, a_v;
    logic               b_valid, b_odd;
    logic signed [31:0] b_r, b_g, b_b;
    logic       c_valid, c_odd;
    logic [7:0] c_r, c_g, c_b;
    logic [7:0] b0_hold, g1_hold, b1_hold;
    logic [17:0] wr_addr;

    logic signed [31:0] ye, ue, ve;
    logic signed [31:0] sum_r, sum_g, sum_b;
    logic signed [31:0] sh_r, sh_g, sh_b;
    logic        emit;
    logic [15:0] word;

    function automatic logic [7:0] clip8(input logic signed [31:0] x);
        if (x < 0)
            return 8'd0;
        else if (x > 32'sd255)
            return 8'hFF;
        else
            return x[7:0];
    endfunction

    function automatic logic [1:0] is_clip(input logic signed [31:0] x);
        return ((x < 0) || (x > 32'sd255)) ? 2'd1 : 2'd0;
    endfunction

    // The second word of an odd pixel costs one cycle with A-C frozen.
    assign advance  = !w2_pend;
    assign in_ready = (state == S_RUN) && (pix_cnt < NP) && !w2_pend;
    assign accept   = in_valid && in_ready;
    assign go       = (state == S_IDLE) && start;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state   <= S_IDLE;
            pix_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        pix_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == NP_M1)
                            state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (last_q) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ye = {{23{a_y[8]}}, a_y};
        ue = {{23{a_u[8]}}, a_u};
        ve = {{23{a_v[8]}}, a_v};
        sum_r = K_Y * ye + K_RV * ve;
        sum_g = K_Y * ye - K_GU * ue - K_GV * ve;
        sum_b = K_Y * ye + K_BU * ue;
        sh_r = b_r >>> 16;
        sh_g = b_g >>> 16;
        sh_b = b_b >>> 16;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
            c_valid <= 1'b0;
            a_odd   <= 1'b0;
            b_odd   <= 1'b0;
            c_odd   <= 1'b0;
        end else if (advance) begin
            a_valid <= accept;
            a_odd   <= pix_cnt[0];
            a_y     <= $signed({1'b0, in_y} - 9'd16);
            a_u     <= $signed({1'b0, in_u} - 9'd128);
            a_v     <= $signed({1'b0, in_v} - 9'd128);
            b_valid <= a_valid;
            b_odd   <= a_odd;
            b_r     <= sum_r;
            b_g     <= sum_g;
            b_b     <= sum_b;
            c_valid <= b_valid;
            c_odd   <= b_odd;
            c_r     <= clip8(sh_r);
            c_g     <= clip8(sh_g);
            c_b     <= clip8(sh_b);
        end
    end

    always_comb begin
        emit = 1'b0;
        word = 16'h0000;
        if (w2_pend) begin
            emit = 1'b1;
            word = {g1_hold, b1_hold};
        end else if (c_valid) begin
            emit = 1'b1;
            word = c_odd ? {b0_hold, c_r} : {c_r, c_g};
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            SRAM_address    <= 18'd0;
            SRAM_write_data <= 16'd0;
            SRAM_we_n       <= 1'b1;
            w2_pend         <= 1'b0;
            last_q          <= 1'b0;
            wr_addr         <= BASE;
            b0_hold         <= 8'd0;
            g1_hold         <= 8'd0;
            b1_hold         <= 8'd0;
        end else begin
            SRAM_we_n <= 1'b1;
            last_q    <= 1'b0;
            if (emit) begin
                SRAM_address    <= wr_addr;
                SRAM_write_data <= word;
                SRAM_we_n       <= 1'b0;
                wr_addr         <= wr_addr + 18'd1;
                last_q          <= (wr_addr == LAST);
            end
            if (w2_pend) begin
                w2_pend <= 1'b0;
            end else if (c_valid && !c_odd) begin
                b0_hold <= c_b;
            end else if (c_valid) begin
                g1_hold <= c_g;
                b1_hold <= c_b;
                w2_pend <= 1'b1;
            end
            if (go)
                wr_addr <= BASE;
        end
    end

`ifdef CSC_CLIP_COUNT_EN
    logic [1:0]  n_clip;
    logic [17:0] clip_sum;
    logic [16:0] clip_q;

    always_comb begin
        n_clip   = is_clip(sh_r) + is_clip(sh_g) + is_clip(sh_b);
        clip_sum = {1'b0, clip_q} + {16'd0, n_clip};
    end

    always_ff @(posedge Clock) begin
        if (!Resetn)
            clip_q <= '0;
        else if (go)
            clip_q <= '0;
        else if (advance && b_valid)
            clip_q <= clip_sum[17] ? '1 : clip_sum[16:0];
    end

    assign clip_count = clip_q;
`else
    assign clip_count = '0;
`endif

endmodule

// File: doc/rgb_csc_writer.md
RGB_CSC_WRITER -- requirements
Module: rgb_csc_writer

Interface
REQ-001 Parameter BASE_ADDR, default 146944, SHALL be the SRAM word address of the first RGB word written.
REQ-002 Parameter NUM_PIXELS, default 76800 (320x240, even), SHALL be the pixel count per frame.
REQ-003 Port Clock  input  1  SHALL be the single clock; all logic is rising-edge triggered.
REQ-004 Port Resetn  input  1  SHALL be the synchronous, active-low reset.
REQ-005 Port start  input  1  SHALL be a one-cycle request to begin a frame.
REQ-006 Port in_valid  input  1  SHALL mark the pixel on in_y/in_u/in_v as valid.
REQ-007 Ports in_y, in_u, in_v  input  8 each  SHALL carry one upsampled YUV pixel (unsigned).
REQ-008 Port in_ready  output  1  SHALL indicate that the block can accept a pixel this cycle.
REQ-009 Port SRAM_address  output  18  SHALL be the registered SRAM write address.
REQ-010 Port SRAM_write_data  output  16  SHALL be the registered SRAM write word.
REQ-011 Port SRAM_we_n  output  1  SHALL be the registered active-low write enable.
REQ-012 Port done  output  1  SHALL be a one-cycle pulse after the last frame word is written.
REQ-013 Port clip_count  output  17  SHALL report saturated components; see Configuration.

Function
REQ-014 FSM states SHALL be S_IDLE, S_RUN and S_FLUSH: S_IDLE->S_RUN on start; S_RUN->S_FLUSH when NUM_PIXELS pixels are accepted; S_FLUSH->S_IDLE when the last word is written.
REQ-015 A start pulse outside S_IDLE SHALL be ignored.
REQ-016 A pixel SHALL be accepted on an edge where in_valid and in_ready are both high.
REQ-017 in_ready SHALL be 1 only in S_RUN, with fewer than NUM_PIXELS accepted, and no pipeline stall.
REQ-018 Pipeline stage A SHALL register the signed 9-bit values Y-16, U-128 and V-128.
REQ-019 Pipeline stage B SHALL compute the following signed 32-bit sums:
  - R = 76284*Y' + 104595*V'
  - G = 76284*Y' - 25624*U' - 53281*V'
  - B = 76284*Y' + 132251*U'
REQ-020 Pipeline stage C SHALL apply an arithmetic right shift by 16, then clip each component to 0..255 (negative->0, >255->255).
REQ-021 Packing SHALL use pixel pair P0,P1 in acceptance order:
  - word0 = {R0,G0}
  - word1 = {B0,R1}
  - word2 = {G1,B1}
REQ-022 Word addresses SHALL be consecutive, starting at BASE_ADDR each frame.
REQ-023 An even pixel leaving stage C SHALL emit word0, and B0 SHALL be held for the next word.
REQ-024 An odd pixel SHALL emit word1 and then word2 on consecutive edges, with stages A-C frozen for one cycle.
REQ-025 in_ready SHALL be 0 during the freeze cycle.
REQ-026 Latency SHALL be 3 edges: a pixel accepted at edge k drives its first write onto the SRAM outputs at edge k+3.
REQ-027 SRAM_we_n SHALL be 1 in any cycle without a word to write; pipeline bubbles are permitted.
REQ-028 Sustained in_valid=1 SHALL yield an in_ready pattern of 1,1,0 repeating, i.e. 3 writes per 2 pixels.
REQ-029 done SHALL pulse in the cycle after the write of address BASE_ADDR + 3*NUM_PIXELS/2 - 1.
REQ-030 Exactly 3*NUM_PIXELS/2 writes SHALL occur per frame, with no address written twice.

Reset
REQ-031 Resetn=0 at a rising edge SHALL set:
  - state = S_IDLE, all pipeline valids = 0, pixel counter = 0;
  - SRAM_address = 0, SRAM_write_data = 0, SRAM_we_n = 1;
  - in_ready = 0, done = 0, clip_count = 0.
REQ-032 Reset mid-frame SHALL drop in-flight pixels; the next start SHALL restart at BASE_ADDR.

Configuration
REQ-033 With macro CSC_CLIP_COUNT_EN defined, clip_count SHALL:
  - increment by the number of components (0-3) clipped in stage C on each advancing edge;
  - saturate at all ones;
  - clear on start.
REQ-034 Without CSC_CLIP_COUNT_EN, clip_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-035 Start, then P0=(16,128,128), P1=(255,128,128) -> writes 0x0000@146944, 0x00FF@146945, 0xFFFF@146946.
REQ-036 Y=235,U=128,V=128 -> R=G=B=254 (floor of 16706196/65536).
REQ-037 Y=16,U=128,V=255 -> R=202, G=0 (clipped), B=0; with CSC_CLIP_COUNT_EN, clip_count increments by 1.
REQ-038 Full frame of 76800 pixels with in_valid held at 1 -> 115200 writes to 146944..262143, each written once, in_ready pattern 1,1,0, exactly one done pulse.
REQ-039 Resetn=0 for one edge mid-frame -> SRAM_we_n=1 and in_ready=0 next cycle; a subsequent start writes from 146944 again.
REQ-040 start asserted while in S_RUN -> no effect on address or count sequence.
